// File: rtl/vx_wb_arbiter.sv
// vx_wb_arbiter: round-robin arbiter that merges the ALU, LSU-load, CSR, FPU
// and GPU commit streams onto the single register-file writeback port through
// a one-entry valid/ready output stage.
// Optional feature: define WB_ARB_STATS_EN to add the grant_count port with
// one 32-bit wrapping grant counter per requester.
module vx_wb_arbiter #(
    parameter int unsigned NUM_REQS = 5,
    parameter int unsigned DATAW    = 64,
    parameter int unsigned SELW     = $clog2(NUM_REQS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      wb_valid,
    output logic [DATAW-1:0]          wb_data,
    output logic [SELW-1:0]           wb_sel,
    input  logic                      wb_ready
`ifdef WB_ARB_STATS_EN
    ,
    output logic [32*NUM_REQS-1:0]    grant_count
`endif
);

    logic [SELW-1:0]  rr_ptr_q;
    logic [SELW-1:0]  rr_ptr_d;
    logic [SELW-1:0]  winner;
    logic [DATAW-1:0] win_data;
    logic             any_valid;
    logic             load_en;
    logic             fire;

    assign any_valid = |req_valid;
    assign load_en   = !wb_valid || wb_ready;
    // Nothing may be accepted while reset is high.
    assign fire      = any_valid && load_en && !reset;

    // Pick the first valid requester at or after rr_ptr, wrapping by compare.
    always_comb begin
        logic [SELW:0]   idx;
        logic [SELW-1:0] cand;
        logic            found;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = {1'b0, rr_ptr_q} + (SELW+1)'(k);
            if (idx >= (SELW+1)'(NUM_REQS)) begin
                idx = idx - (SELW+1)'(NUM_REQS);
            end
            cand = idx[SELW-1:0];
            if (!found && req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Select the winner's payload.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (SELW'(i) == winner) begin
                win_data = req_data[i*DATAW +: DATAW];
            end
        end
    end

    // One-hot accept for the winner, only on a cycle that actually fires.
    always_comb begin
        req_ready = '0;
        if (fire) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Next pointer: one past the winner, wrapping the last index to zero.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fire) begin
            rr_ptr_d = (winner == SELW'(NUM_REQS - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Output stage and pointer; drain without refill clears only the valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_sel   <= '0;
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (fire) begin
                wb_valid <= 1'b1;
                wb_data  <= win_data;
                wb_sel   <= winner;
            end else if (wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [NUM_REQS-1:0][31:0] cnt_q;

    // Per-requester grant counters, wrapping naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (fire) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (SELW'(i) == winner) begin
                    cnt_q[i] <= cnt_q[i] + 32'd1;
                end
            end
        end
    end

    assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Self-checking bench for vx_wb_arbiter: directed vectors with literal
// expectations, a per-cycle behavioural model, and a payload scoreboard.
module tb_vx_wb_arbiter;
    localparam int N  = 5;
    localparam int DW = 64;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            wb_valid;
    logic [DW-1:0]   wb_data;
    logic [SW-1:0]   wb_sel;
    logic            wb_ready = 1'b1;
`ifdef WB_ARB_STATS_EN
    logic [32*N-1:0] grant_count;
`endif

    vx_wb_arbiter #(.NUM_REQS(N), .DATAW(DW), .SELW(SW)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .wb_valid(wb_valid),
        .wb_data(wb_data),
        .wb_sel(wb_sel),
        .wb_ready(wb_ready)
`ifdef WB_ARB_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] hi;
        logic [31:0] lo;
        hi = 32'hC0DE_0000 + 32'(i);
        lo = 32'h1234_5670 + 32'(i);
        return {hi, lo};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: rotating priority from the spec rules, plus a FIFO of
    // accepted payloads that must leave the output stage in grant order.
    int            m_rr = 0;
    bit            m_valid = 0;
    logic [DW-1:0] m_data = '0;
    int            m_sel = 0;
    bit            m_ok = 0;
    int unsigned   m_cnt[N];
    int            wait_f[N];
    logic [DW-1:0] sb[$];

    always @(negedge clk) begin
        int           win;
        int           idx;
        bit           fire;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] dut_fire;
        fire = 0;
        if (m_ok) begin
            win = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (win < 0 && req_valid[idx]) win = idx;
            end
            fire = (win >= 0) && (!m_valid || wb_ready) && !reset;
            exp_rdy = '0;
            if (fire) exp_rdy[win] = 1'b1;
            chk("model_req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("model_wb_valid", 64'(wb_valid), 64'(m_valid));
            chk("model_wb_sel", 64'(wb_sel), 64'(m_sel));
            chk("model_wb_data", wb_data, m_data);
`ifdef WB_ARB_STATS_EN
            for (int i = 0; i < N; i++) begin
                chk("model_grant_count", 64'(grant_count[i*32 +: 32]), 64'(m_cnt[i]));
            end
`endif
            if (!reset && wb_valid && wb_ready) begin
                if (sb.size() == 0) chk("sb_spurious_drain", 64'd1, 64'd0);
                else chk("sb_order", wb_data, sb.pop_front());
            end
            dut_fire = req_valid & req_ready;
            if (reset) begin
                sb.delete();
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (dut_fire[i]) sb.push_back(req_data[i*DW +: DW]);
                end
            end
            if (fire) begin
                for (int i = 0; i < N; i++) begin
                    if (i == win) begin
                        wait_f[i] = 0;
                    end else if (req_valid[i]) begin
                        wait_f[i]++;
                        chk("fair_wait", 64'(wait_f[i] < N), 64'd1);
                    end else begin
                        wait_f[i] = 0;
                    end
                end
            end
        end
        if (reset) begin
            m_ok = 1;
            m_valid = 0;
            m_data = '0;
            m_sel = 0;
            m_rr = 0;
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0;
                wait_f[i] = 0;
            end
        end else if (m_ok) begin
            if (fire) begin
                m_valid = 1;
                m_data = req_data[win*DW +: DW];
                m_sel = win;
                m_rr = (win + 1) % N;
                m_cnt[win]++;
            end else if (wb_ready) begin
                m_valid = 0;
            end
        end
    end

    initial begin
        logic [N-1:0] acc;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pat(i);

        // Reset: outputs clear, req_ready forced low even with all valid.
        reset = 1'b1;
        req_valid = 5'b11111;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_sel", 64'(wb_sel), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        cyc();

        // Single grant to requester 2, one-cycle latency.
        reset = 1'b0;
        req_valid = 5'b00100;
        @(negedge clk);
        chk("t1_req_ready", 64'(req_ready), 64'b00100);
        cyc();
        req_valid = '0;
        @(negedge clk);
        chk("t1_wb_valid", 64'(wb_valid), 64'd1);
        chk("t1_wb_sel", 64'(wb_sel), 64'd2);
        chk("t1_wb_data", wb_data, pat(2));
        cyc();

        // All valid from reset: strict rotation 0..4 twice.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req_valid = 5'b11111;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i > 0) chk("rr_seq_sel", 64'(wb_sel), 64'((i - 1) % 5));
            cyc();
            if (i == 9) req_valid = '0;
        end

        // Backpressure after a grant to 0, then 4 and 0 follow.
        req_valid = 5'b10001;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("bp_first_ready", 64'(req_ready), 64'b00001);
        cyc();
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(wb_valid), 64'd1);
            chk("bp_hold_sel", 64'(wb_sel), 64'd0);
            chk("bp_hold_data", wb_data, pat(0));
            chk("bp_hold_ready", 64'(req_ready), 64'd0);
            cyc();
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_4", 64'(req_ready), 64'b10000);
        cyc();
        @(negedge clk);
        chk("bp_sel_4", 64'(wb_sel), 64'd4);
        chk("bp_ready_0", 64'(req_ready), 64'b00001);
        cyc();

        // Reset while an entry is pending and the pointer sits at 1.
        req_valid = 5'b00011;
        wb_ready = 1'b0;
        @(negedge clk);
        chk("rm_pre_sel", 64'(wb_sel), 64'd0);
        chk("rm_pre_valid", 64'(wb_valid), 64'd1);
        cyc();
        reset = 1'b1;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("rm_ready_in_reset", 64'(req_ready), 64'd0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rm_wb_valid", 64'(wb_valid), 64'd0);
        chk("rm_ready_ptr0", 64'(req_ready), 64'b00001);
        cyc();
        @(negedge clk);
        chk("rm_first_sel", 64'(wb_sel), 64'd0);
        cyc();

        // Single requester wins every cycle regardless of pointer.
        req_valid = 5'b01000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("single_ready", 64'(req_ready), 64'b01000);
            cyc();
        end
        @(negedge clk);
        chk("single_sel", 64'(wb_sel), 64'd3);
        req_valid = '0;
        cyc();
        cyc();

        // Random traffic obeying the hold-while-waiting rule.
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            cyc();
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !acc[i])) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_data[i*DW +: DW] = {$urandom, $urandom};
                end
            end
            wb_ready = ($urandom_range(0, 3) != 0);
        end

        // 100 fires with all valid: 20 grants each.
        req_valid = '0;
        wb_ready = 1'b1;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req_valid = 5'b11111;
        for (int i = 0; i < 100; i++) cyc();
        req_valid = '0;
        @(negedge clk);
`ifdef WB_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk("stats_grant_20", 64'(grant_count[i*32 +: 32]), 64'd20);
        end
`endif
        chk("stats_end_sel", 64'(wb_sel), 64'd4);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
